apb_master_arbiter: RTL and testbench

Shares one APB master port among `NREQ` requesters: test-bench sequencers, the BFM command path, and register-init engines. It arbitrates round-robin and sequences each granted request through the APB SETUP and ACCESS phases. It decodes the 16 slave selects from the address, the same slot scheme as our AHB-to-APB bridge. It also bounds slave wait states with a timeout. It sits between the requesters and the shared `PSEL[15:0]`/`PADDR`/`PWDATA` bus feeding the peripheral slots (CoreUARTapb etc.).

---
 rtl/apb_arb_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/apb_master_arbiter.sv | 178 +++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB master arbiter: FSM states, slot decode
// field and the APB data width.
package apb_arb_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StAccess,
      StDone
   } apb_state_e;

   localparam int unsigned SLOT_MSB = 27;
   localparam int unsigned SLOT_LSB = 24;
   localparam int unsigned APB_DW   = 32;
   localparam int unsigned NSLOT    = 16;

   // One-hot slave select from the slot field; bits 31:28 do not take part.
   function automatic logic [NSLOT-1:0] slot_decode(input logic [APB_DW-1:0] addr);
      logic [NSLOT-1:0] sel;
      sel = '0;
      sel[addr[SLOT_MSB:SLOT_LSB]] = 1'b1;
      return sel;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts at the requester after last_gnt
// and wraps, so the previous winner has the lowest priority.
module rr_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IdxW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IdxW-1:0] last_gnt,
   output logic [NREQ-1:0] gnt,
   output logic [IdxW-1:0] gnt_idx
);

   int unsigned     cand_int;
   logic [IdxW-1:0] cand;
   logic            found;

   always_comb begin
      gnt      = '0;
      gnt_idx  = '0;
      found    = 1'b0;
      cand_int = 0;
      cand     = '0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         cand_int = (32'(last_gnt) + i) % NREQ;
         cand     = IdxW'(cand_int);
         if (!found && req[cand]) begin
            gnt[cand] = 1'b1;
            gnt_idx   = cand;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port among NREQ requesters: round-robin arbitration, SETUP/ACCESS
// sequencing, slot-based PSEL decode and a bounded wait-state timeout.
module apb_master_arbiter
   import apb_arb_pkg::*;
#(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned TIMEOUT = 256
) (
   input  logic                   PCLK,
   input  logic                   PRESET,
   input  logic [NREQ-1:0]        REQ,
   input  logic [NREQ*APB_DW-1:0] REQ_ADDR,
   input  logic [NREQ-1:0]        REQ_WRITE,
   input  logic [NREQ*APB_DW-1:0] REQ_WDATA,
   output logic [NREQ-1:0]        GNT,
   output logic [NREQ-1:0]        DONE,
   output logic [APB_DW-1:0]      RDATA,
   output logic                   SLVERR,
   output logic                   BUSY,
   output logic [APB_DW-1:0]      PADDR,
   output logic [NSLOT-1:0]       PSEL,
   output logic                   PENABLE,
   output logic                   PWRITE,
   output logic [APB_DW-1:0]      PWDATA,
   input  logic [APB_DW-1:0]      PRDATA,
   input  logic                   PREADY,
   input  logic                   PSLVERR
);

   localparam int unsigned IdxW  = $clog2(NREQ);
   localparam int unsigned WaitW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WaitW-1:0] WaitLast = (TIMEOUT > 0) ? WaitW'(TIMEOUT - 1) : '0;

   apb_state_e state_q, state_d;

   logic [IdxW-1:0]   last_gnt_q, last_gnt_d;
   logic [IdxW-1:0]   gnt_idx_q, gnt_idx_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   done_q, done_d;
   logic [APB_DW-1:0] rdata_q, rdata_d;
   logic              slverr_q, slverr_d;
   logic [APB_DW-1:0] paddr_q, paddr_d;
   logic [NSLOT-1:0]  psel_q, psel_d;
   logic              penable_q, penable_d;
   logic              pwrite_q, pwrite_d;
   logic [APB_DW-1:0] pwdata_q, pwdata_d;
   logic [WaitW-1:0]  wait_q, wait_d;

   logic [APB_DW-1:0] addr_arr  [NREQ];
   logic [APB_DW-1:0] wdata_arr [NREQ];
   logic [NREQ-1:0]   win_gnt;
   logic [IdxW-1:0]   win_idx;

   for (genvar g = 0; g < NREQ; g++) begin : g_unpack
      assign addr_arr[g]  = REQ_ADDR[g*APB_DW +: APB_DW];
      assign wdata_arr[g] = REQ_WDATA[g*APB_DW +: APB_DW];
   end

   rr_arbiter #(
      .NREQ (NREQ),
      .IdxW (IdxW)
   ) u_rr_arbiter (
      .req      (REQ),
      .last_gnt (last_gnt_q),
      .gnt      (win_gnt),
      .gnt_idx  (win_idx)
   );

   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      gnt_idx_d  = gnt_idx_q;
      gnt_d      = gnt_q;
      done_d     = done_q;
      rdata_d    = rdata_q;
      slverr_d   = slverr_q;
      paddr_d    = paddr_q;
      psel_d     = psel_q;
      penable_d  = penable_q;
      pwrite_d   = pwrite_q;
      pwdata_d   = pwdata_q;
      wait_d     = wait_q;

      unique case (state_q)
         StIdle: begin
            if (|REQ) begin
               state_d   = StSetup;
               gnt_d     = win_gnt;
               gnt_idx_d = win_idx;
               paddr_d   = addr_arr[win_idx];
               pwrite_d  = REQ_WRITE[win_idx];
               pwdata_d  = wdata_arr[win_idx];
               psel_d    = slot_decode(addr_arr[win_idx]);
            end
         end
         StSetup: begin
            state_d   = StAccess;
            penable_d = 1'b1;
            wait_d    = '0;
         end
         StAccess: begin
            if (PREADY) begin
               state_d   = StDone;
               psel_d    = '0;
               penable_d = 1'b0;
               done_d    = gnt_q;
               rdata_d   = pwrite_q ? '0 : PRDATA;
               slverr_d  = PSLVERR;
            end else if (TIMEOUT != 0 && wait_q == WaitLast) begin
               // Slave never answered: complete with an error so the bus is not held forever.
               state_d   = StDone;
               psel_d    = '0;
               penable_d = 1'b0;
               done_d    = gnt_q;
               rdata_d   = '0;
               slverr_d  = 1'b1;
            end else if (wait_q != '1) begin
               wait_d = wait_q + WaitW'(1);
            end
         end
         StDone: begin
            state_d    = StIdle;
            done_d     = '0;
            gnt_d      = '0;
            rdata_d    = '0;
            slverr_d   = 1'b0;
            last_gnt_d = gnt_idx_q;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         state_q    <= StIdle;
         last_gnt_q <= IdxW'(NREQ - 1);
         gnt_idx_q  <= '0;
         gnt_q      <= '0;
         done_q     <= '0;
         rdata_q    <= '0;
         slverr_q   <= 1'b0;
         paddr_q    <= '0;
         psel_q     <= '0;
         penable_q  <= 1'b0;
         pwrite_q   <= 1'b0;
         pwdata_q   <= '0;
         wait_q     <= '0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         gnt_idx_q  <= gnt_idx_d;
         gnt_q      <= gnt_d;
         done_q     <= done_d;
         rdata_q    <= rdata_d;
         slverr_q   <= slverr_d;
         paddr_q    <= paddr_d;
         psel_q     <= psel_d;
         penable_q  <= penable_d;
         pwrite_q   <= pwrite_d;
         pwdata_q   <= pwdata_d;
         wait_q     <= wait_d;
      end
   end

   assign GNT     = gnt_q;
   assign DONE    = done_q;
   assign RDATA   = rdata_q;
   assign SLVERR  = slverr_q;
   assign BUSY    = (state_q != StIdle);
   assign PADDR   = paddr_q;
   assign PSEL    = psel_q;
   assign PENABLE = penable_q;
   assign PWRITE  = pwrite_q;
   assign PWDATA  = pwdata_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter: single write, waited read, slave error, timeout,
// round-robin ordering and reset in the middle of a transfer.
module tb_apb_master_arbiter;

   localparam int unsigned NREQ    = 4;
   localparam int unsigned TIMEOUT = 8;

   logic                PCLK;
   logic                PRESET;
   logic [NREQ-1:0]     REQ;
   logic [NREQ*32-1:0]  REQ_ADDR;
   logic [NREQ-1:0]     REQ_WRITE;
   logic [NREQ*32-1:0]  REQ_WDATA;
   logic [NREQ-1:0]     GNT;
   logic [NREQ-1:0]     DONE;
   logic [31:0]         RDATA;
   logic                SLVERR;
   logic                BUSY;
   logic [31:0]         PADDR;
   logic [15:0]         PSEL;
   logic                PENABLE;
   logic                PWRITE;
   logic [31:0]         PWDATA;
   logic [31:0]         PRDATA;
   logic                PREADY;
   logic                PSLVERR;

   int n_tests = 0;
   int n_fail  = 0;

   apb_master_arbiter #(
      .NREQ    (NREQ),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .PCLK      (PCLK),
      .PRESET    (PRESET),
      .REQ       (REQ),
      .REQ_ADDR  (REQ_ADDR),
      .REQ_WRITE (REQ_WRITE),
      .REQ_WDATA (REQ_WDATA),
      .GNT       (GNT),
      .DONE      (DONE),
      .RDATA     (RDATA),
      .SLVERR    (SLVERR),
      .BUSY      (BUSY),
      .PADDR     (PADDR),
      .PSEL      (PSEL),
      .PENABLE   (PENABLE),
      .PWRITE    (PWRITE),
      .PWDATA    (PWDATA),
      .PRDATA    (PRDATA),
      .PREADY    (PREADY),
      .PSLVERR   (PSLVERR)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".GNT"},     32'(GNT),     32'h0);
      chk({tag, ".DONE"},    32'(DONE),    32'h0);
      chk({tag, ".RDATA"},   RDATA,        32'h0);
      chk({tag, ".SLVERR"},  32'(SLVERR),  32'h0);
      chk({tag, ".BUSY"},    32'(BUSY),    32'h0);
      chk({tag, ".PADDR"},   PADDR,        32'h0);
      chk({tag, ".PSEL"},    32'(PSEL),    32'h0);
      chk({tag, ".PENABLE"}, 32'(PENABLE), 32'h0);
      chk({tag, ".PWRITE"},  32'(PWRITE),  32'h0);
      chk({tag, ".PWDATA"},  PWDATA,       32'h0);
   endtask

   logic [3:0] rr_exp [5];

   initial begin
      PRESET    = 1'b1;
      REQ       = '0;
      REQ_ADDR  = '0;
      REQ_WRITE = '0;
      REQ_WDATA = '0;
      PRDATA    = '0;
      PREADY    = 1'b1;
      PSLVERR   = 1'b0;
      rr_exp[0] = 4'b0001;
      rr_exp[1] = 4'b0010;
      rr_exp[2] = 4'b0100;
      rr_exp[3] = 4'b1000;
      rr_exp[4] = 4'b0001;

      tick();
      tick();
      chk_all_zero("reset");
      PRESET = 1'b0;

      // Single zero-wait write from requester 0.
      REQ_ADDR[31:0]  = 32'h0500_0010;
      REQ_WDATA[31:0] = 32'hDEAD_BEEF;
      REQ_WRITE       = 4'b0001;
      PRDATA          = 32'hFFFF_FFFF;
      REQ             = 4'b0001;
      tick();
      chk("wr.setup.PSEL",    32'(PSEL),    32'h0020);
      chk("wr.setup.PENABLE", 32'(PENABLE), 32'h0);
      chk("wr.setup.GNT",     32'(GNT),     32'h1);
      chk("wr.setup.PADDR",   PADDR,        32'h0500_0010);
      chk("wr.setup.PWDATA",  PWDATA,       32'hDEAD_BEEF);
      chk("wr.setup.PWRITE",  32'(PWRITE),  32'h1);
      chk("wr.setup.BUSY",    32'(BUSY),    32'h1);
      tick();
      chk("wr.access.PENABLE", 32'(PENABLE), 32'h1);
      chk("wr.access.PSEL",    32'(PSEL),    32'h0020);
      chk("wr.access.DONE",    32'(DONE),    32'h0);
      tick();
      chk("wr.done.DONE",   32'(DONE),   32'h1);
      chk("wr.done.SLVERR", 32'(SLVERR), 32'h0);
      chk("wr.done.RDATA",  RDATA,       32'h0);
      chk("wr.done.PSEL",   32'(PSEL),   32'h0);
      REQ = '0;
      tick();
      chk("wr.idle.BUSY", 32'(BUSY), 32'h0);
      chk("wr.idle.GNT",  32'(GNT),  32'h0);
      chk("wr.idle.DONE", 32'(DONE), 32'h0);

      // Read from requester 1 with three wait states.
      REQ_ADDR[63:32] = 32'h0A00_0004;
      REQ_WRITE       = 4'b0000;
      PRDATA          = 32'h1234_5678;
      PREADY          = 1'b0;
      REQ             = 4'b0010;
      tick();
      chk("rd.setup.PSEL", 32'(PSEL), 32'h0400);
      chk("rd.setup.GNT",  32'(GNT),  32'h2);
      tick();
      tick();
      tick();
      tick();
      chk("rd.c5.PENABLE", 32'(PENABLE), 32'h1);
      chk("rd.c5.DONE",    32'(DONE),    32'h0);
      PREADY = 1'b1;
      tick();
      chk("rd.c6.DONE",  32'(DONE), 32'h2);
      chk("rd.c6.RDATA", RDATA,     32'h1234_5678);
      REQ = '0;
      tick();

      // Write to slot 15 with upper address bits set; slave flags an error.
      REQ_ADDR[95:64]  = 32'hFF00_0000;
      REQ_WDATA[95:64] = 32'h5555_AAAA;
      REQ_WRITE        = 4'b0100;
      PSLVERR          = 1'b1;
      REQ              = 4'b0100;
      tick();
      chk("err.setup.PSEL",  32'(PSEL), 32'h8000);
      chk("err.setup.PADDR", PADDR,     32'hFF00_0000);
      tick();
      tick();
      chk("err.done.DONE",   32'(DONE),   32'h4);
      chk("err.done.SLVERR", 32'(SLVERR), 32'h1);
      REQ     = '0;
      PSLVERR = 1'b0;
      tick();

      // Timeout: requester 3 reads slot 0 with PREADY stuck low.
      REQ_ADDR[127:96] = 32'h0000_0008;
      REQ_WRITE        = 4'b0000;
      PRDATA           = 32'hCAFE_F00D;
      PREADY           = 1'b0;
      REQ              = 4'b1000;
      tick();
      chk("to.setup.PSEL", 32'(PSEL), 32'h0001);
      for (int i = 0; i < 8; i++) tick();
      chk("to.c9.DONE",    32'(DONE),    32'h0);
      chk("to.c9.PENABLE", 32'(PENABLE), 32'h1);
      tick();
      chk("to.c10.DONE",   32'(DONE),   32'h8);
      chk("to.c10.SLVERR", 32'(SLVERR), 32'h1);
      chk("to.c10.RDATA",  RDATA,       32'h0);
      REQ = '0;
      tick();
      REQ_ADDR[31:0] = 32'h0300_0000;
      REQ_WRITE      = 4'b0000;
      PRDATA         = 32'h0BAD_F00D;
      PREADY         = 1'b1;
      REQ            = 4'b0001;
      tick();
      chk("after_to.setup.PSEL", 32'(PSEL), 32'h0008);
      tick();
      tick();
      chk("after_to.DONE",   32'(DONE),   32'h1);
      chk("after_to.RDATA",  RDATA,       32'h0BAD_F00D);
      chk("after_to.SLVERR", 32'(SLVERR), 32'h0);
      REQ = '0;
      tick();

      // Round-robin with all requesters asserting continuously from reset.
      PRESET = 1'b1;
      tick();
      PRESET    = 1'b0;
      REQ_WRITE = 4'b1111;
      REQ       = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("rr%0d.GNT", k), 32'(GNT), 32'(rr_exp[k]));
         tick();
         tick();
         chk($sformatf("rr%0d.DONE", k), 32'(DONE), 32'(rr_exp[k]));
         if (k == 4) REQ = '0;
         tick();
         chk($sformatf("rr%0d.idle", k), 32'(BUSY), 32'h0);
      end

      // Reset during a waited read from requester 2; last grantee before reset was 0.
      REQ_ADDR[95:64] = 32'h0200_0000;
      REQ_WRITE       = 4'b0000;
      PREADY          = 1'b0;
      REQ             = 4'b0100;
      tick();
      chk("mid.setup.GNT", 32'(GNT), 32'h4);
      tick();
      tick();
      PRESET = 1'b1;
      tick();
      chk_all_zero("mid.reset");
      PRESET = 1'b0;
      PREADY = 1'b1;
      REQ    = 4'b0101;
      tick();
      chk("mid.after.GNT", 32'(GNT), 32'h1);
      tick();
      chk("mid.after.DONE_early", 32'(DONE), 32'h0);
      tick();
      chk("mid.after.DONE", 32'(DONE), 32'h1);
      REQ = '0;
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
